// File: rtl/vec_sumsq_unit.sv
// Purpose : streaming multi-lane reduction unit (sum of squares, dot product, squared difference).
// Latency : result valid in the cycle after edge E+2, where E accepts the last beat; Len=0 answers the cycle after Start.
// Backpres: InReady is registered and independent of InValid; the result is held in DONE until OutValid&&OutReady.
// Ports   : clk/rst_n clock and async active-low reset; Start/Mode/Len job launch; InValid/InReady/OpA/OpB beat stream;
//           OutValid/OutReady/AluOut/Overflow result handshake; Busy high whenever a job is in progress.
`timescale 1ns/1ps
module vec_sumsq_unit #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Start,
  input  logic [1:0]             Mode,
  input  logic [LEN_W-1:0]       Len,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [LANES*WIDTH-1:0] OpA,
  input  logic [LANES*WIDTH-1:0] OpB,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [ACC_W-1:0]       AluOut,
  output logic                   Overflow,
  output logic                   Busy
);

  // One spare bit so a*a + b*b never loses its carry.
  localparam int TERM_W = 2*WIDTH + 1;
  localparam int SUM_W  = TERM_W + $clog2(LANES);
  localparam int TOT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [LEN_W-1:0]       cnt;
  logic [LEN_W-1:0]       len_q;
  logic [1:0]             mode_q;
  logic [ACC_W-1:0]       acc;
  logic                   ovf;

  logic                   in_vld;
  logic [LANES*WIDTH-1:0] a_q;
  logic [LANES*WIDTH-1:0] b_q;
  logic                   s1_vld;
  logic [TERM_W-1:0]      term_q [LANES];
  logic [TERM_W-1:0]      term_d [LANES];
  logic [SUM_W-1:0]       sum;
  logic [TOT_W-1:0]       tot;
  logic                   accept;

  function automatic logic [TERM_W-1:0] lane_term(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0]   d;
    logic [2*WIDTH-1:0] aa, bb, ab, dd;
    d  = (a >= b) ? (a - b) : (b - a);
    aa = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, a};
    bb = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, b};
    ab = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    dd = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    case (m)
      2'b01:   lane_term = {1'b0, ab};
      2'b10:   lane_term = {1'b0, dd};
      default: lane_term = {1'b0, aa} + {1'b0, bb};  // 00 and 11 both mean SUMSQ
    endcase
  endfunction

  assign accept   = InValid && InReady;
  assign AluOut   = acc;
  assign Overflow = ovf;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      term_d[i] = lane_term(mode_q, a_q[i*WIDTH +: WIDTH], b_q[i*WIDTH +: WIDTH]);
    end
  end

  // Adder tree plus accumulate at full precision; any bit above ACC_W is an overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(term_q[i]);
    end
    tot = TOT_W'(acc) + TOT_W'(sum);
  end

  // Operand capture register, then the registered per-lane products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      s1_vld <= 1'b0;
      for (int i = 0; i < LANES; i++) term_q[i] <= '0;
    end else begin
      in_vld <= accept;
      if (accept) begin
        a_q <= OpA;
        b_q <= OpB;
      end
      s1_vld <= in_vld;
      if (in_vld) begin
        for (int i = 0; i < LANES; i++) term_q[i] <= term_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      mode_q   <= 2'b00;
      acc      <= '0;
      ovf      <= 1'b0;
      InReady  <= 1'b0;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      if (s1_vld) begin
        acc <= tot[ACC_W-1:0];
        ovf <= ovf | (|tot[TOT_W-1:ACC_W]);
      end
      case (state)
        IDLE: begin
          if (Start) begin
            mode_q <= Mode;
            len_q  <= Len;
            cnt    <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            Busy   <= 1'b1;
            if (Len != '0) begin
              state   <= RUN;
              InReady <= 1'b1;
            end else begin
              state    <= DONE;
              OutValid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt + LEN_W'(1) == len_q) begin
              state   <= DRAIN;
              InReady <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // With the capture stage empty, the product stage is retired into acc on
          // this same edge, so the result is final once we land in DONE.
          if (!in_vld) begin
            state    <= DONE;
            OutValid <= 1'b1;
          end
        end
        DONE: begin
          if (OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_sumsq_unit.sv
`timescale 1ns/1ps
module tb_vec_sumsq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [1:0]  Mode;
  logic [7:0]  Len;
  logic        InValid;
  logic        InReady;
  logic [63:0] OpA;
  logic [63:0] OpB;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] AluOut;
  logic        Overflow;
  logic        Busy;

  int vectors    = 0;
  int miscompares = 0;

  vec_sumsq_unit #(.WIDTH(32), .LANES(2), .ACC_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Mode(Mode), .Len(Len),
    .InValid(InValid), .InReady(InReady), .OpA(OpA), .OpB(OpB),
    .OutValid(OutValid), .OutReady(OutReady), .AluOut(AluOut),
    .Overflow(Overflow), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] m, input logic [7:0] l);
    Mode  = m;
    Len   = l;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b);
    InValid = 1'b1;
    OpA     = a;
    OpB     = b;
    tick();
    InValid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (OutValid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, OutValid}, 64'd1);
  endtask

  task automatic take_result();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; Mode = 2'b00; Len = 8'd0;
    InValid = 1'b0; OpA = '0; OpB = '0; OutReady = 1'b0;
    #23;
    chk("rst_inready",  {63'd0, InReady},  64'd0);
    chk("rst_outvalid", {63'd0, OutValid}, 64'd0);
    chk("rst_busy",     {63'd0, Busy},     64'd0);
    chk("rst_overflow", {63'd0, Overflow}, 64'd0);
    chk("rst_aluout",   {32'd0, AluOut},   64'd0);
    rst_n = 1'b1;
    tick();

    // Legacy SUMSQ: 3*3 + 4*4 = 25, lane 1 held at zero.
    start_job(2'b00, 8'd1);
    chk("sumsq_inready", {63'd0, InReady}, 64'd1);
    chk("sumsq_busy",    {63'd0, Busy},    64'd1);
    send(64'd3, 64'd4);
    chk("sumsq_ov_e0", {63'd0, OutValid}, 64'd0);
    chk("sumsq_ir_e0", {63'd0, InReady},  64'd0);
    tick();
    chk("sumsq_ov_e1", {63'd0, OutValid}, 64'd0);
    tick();
    chk("sumsq_ov_e2", {63'd0, OutValid}, 64'd1);
    chk("sumsq_out",   {32'd0, AluOut},   64'd25);
    chk("sumsq_ovf",   {63'd0, Overflow}, 64'd0);
    take_result();
    chk("sumsq_idle_ov",   {63'd0, OutValid}, 64'd0);
    chk("sumsq_idle_busy", {63'd0, Busy},     64'd0);

    // DOT, 3 beats back-to-back: 23 + 67 + 127 = 217.
    start_job(2'b01, 8'd3);
    chk("dot_ir_b1", {63'd0, InReady}, 64'd1);
    send({32'd2, 32'd1}, {32'd8, 32'd7});
    chk("dot_ir_b2", {63'd0, InReady}, 64'd1);
    send({32'd4, 32'd3}, {32'd10, 32'd9});
    chk("dot_ir_b3", {63'd0, InReady}, 64'd1);
    send({32'd6, 32'd5}, {32'd12, 32'd11});
    chk("dot_ir_fall", {63'd0, InReady}, 64'd0);
    tick();
    chk("dot_ov_e1", {63'd0, OutValid}, 64'd0);
    tick();
    chk("dot_ov_e2", {63'd0, OutValid}, 64'd1);
    chk("dot_out",   {32'd0, AluOut},   64'd217);
    chk("dot_ovf",   {63'd0, Overflow}, 64'd0);
    take_result();

    // DIFFSQ with a 2-cycle input gap: 7^2 + 3^2 = 58.
    start_job(2'b10, 8'd2);
    send(64'd10, 64'd3);
    tick();
    chk("diff_gap_ir", {63'd0, InReady}, 64'd1);
    tick();
    send(64'd2, 64'd5);
    wait_out("diff_done");
    chk("diff_out", {32'd0, AluOut}, 64'd58);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        Mode = 2'b01; Len = 8'd0; Start = 1'b1;
      end
      tick();
      Start = 1'b0;
      chk("diff_hold_out",  {32'd0, AluOut},   64'd58);
      chk("diff_hold_ov",   {63'd0, OutValid}, 64'd1);
      chk("diff_hold_busy", {63'd0, Busy},     64'd1);
    end
    chk("diff_ovf", {63'd0, Overflow}, 64'd0);
    take_result();
    chk("diff_idle_busy", {63'd0, Busy}, 64'd0);

    // Zero length: result straight away, no beat taken.
    start_job(2'b01, 8'd0);
    chk("zero_ov",  {63'd0, OutValid}, 64'd1);
    chk("zero_out", {32'd0, AluOut},   64'd0);
    chk("zero_ir",  {63'd0, InReady},  64'd0);
    chk("zero_ovf", {63'd0, Overflow}, 64'd0);
    take_result();

    // Overflow: (2^32-1)^2 mod 2^32 = 1.
    start_job(2'b00, 8'd1);
    send(64'h0000_0000_FFFF_FFFF, 64'd0);
    wait_out("ovf_done");
    chk("ovf_out",  {32'd0, AluOut},   64'd1);
    chk("ovf_flag", {63'd0, Overflow}, 64'd1);
    take_result();
    start_job(2'b00, 8'd1);
    send(64'd1, 64'd1);
    wait_out("ovf2_done");
    chk("ovf2_out",  {32'd0, AluOut},   64'd2);
    chk("ovf2_flag", {63'd0, Overflow}, 64'd0);
    take_result();

    // Reset mid-job after 2 of 4 DOT beats.
    start_job(2'b01, 8'd4);
    send({32'd1, 32'd1}, {32'd1, 32'd1});
    send({32'd2, 32'd2}, {32'd2, 32'd2});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ir",   {63'd0, InReady},  64'd0);
    chk("mid_rst_busy", {63'd0, Busy},     64'd0);
    chk("mid_rst_ov",   {63'd0, OutValid}, 64'd0);
    chk("mid_rst_out",  {32'd0, AluOut},   64'd0);
    chk("mid_rst_ovf",  {63'd0, Overflow}, 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    start_job(2'b01, 8'd1);
    send({32'd3, 32'd2}, {32'd5, 32'd4});
    wait_out("post_rst_done");
    chk("post_rst_out", {32'd0, AluOut}, 64'd23);
    take_result();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
